// File: rtl/instruction_fetch_pkg.sv
// Shared encodings for the instruction fetch stage: next-PC select, special
// instruction words and fetch FSM states.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'b00,
        PC_SRC_BRANCH = 2'b01,
        PC_SRC_JUMP   = 2'b10,
        PC_SRC_JR     = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } fetch_state_e;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: synchronous write for program loading,
// combinational read for same-cycle fetch. Contents survive reset.
module instruction_memory #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [NB_ADDR-1:0] i_waddr,
    input  logic [NB_DATA-1:0] i_wdata,
    input  logic [NB_ADDR-1:0] i_raddr,
    output logic [NB_DATA-1:0] o_rdata
);

    logic [NB_DATA-1:0] mem_q [2**NB_ADDR];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, next-PC mux, IF/ID pipeline register and the
// IDLE/RUN/HALTED control FSM around an instruction memory.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_load_en,
    input  logic [NB_ADDR-1:0] i_load_addr,
    input  logic [NB_DATA-1:0] i_load_data,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic [1:0]         i_pc_src,
    input  logic [NB_DATA-1:0] i_branch_target,
    input  logic [NB_DATA-1:0] i_jump_target,
    input  logic [NB_DATA-1:0] i_jr_target,
    output logic [NB_DATA-1:0] o_instr,
    output logic [NB_DATA-1:0] o_pc_plus4,
    output logic [NB_DATA-1:0] o_pc,
    output logic               o_valid,
    output logic               o_halted
);

    localparam logic [NB_DATA-1:0] HALT = NB_DATA'(HALT_WORD);
    localparam logic [NB_DATA-1:0] NOP  = NB_DATA'(NOP_WORD);

    fetch_state_e       state_q, state_d;
    logic [NB_DATA-1:0] pc_q, pc_d;
    logic [NB_DATA-1:0] instr_q, instr_d;
    logic [NB_DATA-1:0] pc_plus4_q, pc_plus4_d;
    logic               valid_q, valid_d;

    logic [NB_DATA-1:0] mem_word;
    logic [NB_DATA-1:0] pc_seq;
    logic [NB_DATA-1:0] pc_redirect;

    // Loading is only allowed while the stage is parked in IDLE.
    instruction_memory #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_imem (
        .i_clk   (i_clk),
        .i_we    (i_load_en && (state_q == ST_IDLE)),
        .i_waddr (i_load_addr),
        .i_wdata (i_load_data),
        .i_raddr (pc_q[NB_ADDR+1:2]),
        .o_rdata (mem_word)
    );

    assign pc_seq = pc_q + NB_DATA'(4);

    always_comb begin
        pc_redirect = pc_seq;
        unique case (pc_src_e'(i_pc_src))
            PC_SRC_SEQ:    pc_redirect = pc_seq;
            PC_SRC_BRANCH: pc_redirect = i_branch_target;
            PC_SRC_JUMP:   pc_redirect = i_jump_target;
            PC_SRC_JR:     pc_redirect = i_jr_target;
            default:       pc_redirect = pc_seq;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_flush) begin
                    instr_d = NOP;
                    valid_d = 1'b0;
                    pc_d    = pc_redirect;
                end else if (!i_stall) begin
                    instr_d    = mem_word;
                    pc_plus4_d = pc_seq;
                    valid_d    = 1'b1;
                    // A latched HALT pins the PC just past itself, ignoring redirects.
                    if (mem_word == HALT) begin
                        pc_d    = pc_seq;
                        state_d = ST_HALTED;
                    end else begin
                        pc_d = pc_redirect;
                    end
                end
            end
            ST_HALTED: begin
                instr_d = NOP;
                valid_d = 1'b0;
                if (i_start) begin
                    state_d    = ST_IDLE;
                    pc_d       = '0;
                    pc_plus4_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            instr_q    <= NOP;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign o_instr    = instr_q;
    assign o_pc_plus4 = pc_plus4_q;
    assign o_pc       = pc_q;
    assign o_valid    = valid_q;
    assign o_halted   = (state_q == ST_HALTED);

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter NB_DATA, default 32: instruction and PC width.
REQ-002 Parameter NB_ADDR, default 8: instruction-memory word-address width (256 words).
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_reset  in  1  asynchronous, active-low reset.
REQ-005 i_start  in  1  one-cycle pulse; IDLE->RUN.
REQ-006 i_load_en  in  1  write i_load_data into instruction memory at i_load_addr; honoured in IDLE only.
REQ-007 i_load_addr  in  NB_ADDR  word address for loading.
REQ-008 i_load_data  in  NB_DATA  instruction word for loading.
REQ-009 i_stall  in  1  hold PC and IF/ID (from hazard unit).
REQ-010 i_flush  in  1  squash IF/ID contents to NOP.
REQ-011 i_pc_src  in  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jump-register.
REQ-012 i_branch_target, i_jump_target, i_jr_target  in  NB_DATA each  redirect addresses.
REQ-013 o_instr  out  NB_DATA  IF/ID instruction.
REQ-014 o_pc_plus4  out  NB_DATA  IF/ID PC+4 of o_instr.
REQ-015 o_pc  out  NB_DATA  current PC register value.
REQ-016 o_valid  out  1  IF/ID holds a real fetched instruction.
REQ-017 o_halted  out  1  high while in HALTED state.

Function
REQ-018 FSM states IDLE, RUN, HALTED; IDLE->RUN on i_start; RUN->HALTED when HALT word (all ones) is latched into IF/ID; HALTED->IDLE on i_start; i_start in RUN ignored.
REQ-019 Instruction memory read is combinational, index = PC[NB_ADDR+1:2]; PC bits [1:0] and above NB_ADDR+1 ignored for indexing (index wraps).
REQ-020 PC write enable = RUN and (not i_stall or i_flush); next PC per i_pc_src; PC+4 wraps modulo 2^NB_DATA.
REQ-021 IF/ID update in RUN: i_flush -> o_instr=0, o_valid=0 (flush beats stall); else i_stall -> hold; else latch memory word, PC+4, o_valid=1.
REQ-022 Fetch-to-o_instr latency exactly one cycle; redirect target fetched in the cycle after i_pc_src!=00 with PC write enabled.
REQ-023 On HALT latch, PC stops at HALT address+4; from next cycle o_instr=0, o_valid=0 until leaving HALTED.
REQ-024 In IDLE and HALTED: PC, IF/ID frozen except as in REQ-023; i_stall, i_flush, i_pc_src ignored.
REQ-025 i_load_en in RUN or HALTED is ignored; memory contents unchanged.
REQ-026 HALTED->IDLE transition resets PC to 0 and IF/ID to NOP so a new program can run.

Reset
REQ-027 Reset (i_reset low) asynchronously forces: PC=0, o_instr=0, o_pc_plus4=0, o_valid=0, o_halted=0, state IDLE.
REQ-028 Instruction memory contents are not cleared by reset.
REQ-029 Reset asserted mid-RUN aborts fetch immediately; release returns to IDLE, requiring i_start.

Structure
REQ-030 Shared package holds pc_src encodings, HALT word (32'hFFFFFFFF), NOP word (0), FSM state encodings.
REQ-031 Instruction memory is sub-module instruction_memory (NB_DATA, NB_ADDR): sync write, async read.
REQ-032 PC register, next-PC mux, IF/ID register and FSM live in instruction_fetch.

Verification
REQ-033 Load 0x11111111,0x22222222,0xFFFFFFFF at words 0..2, pulse i_start -> o_instr 0x11111111 (o_pc_plus4=4), 0x22222222 (8), 0xFFFFFFFF (12), then o_halted=1, o_pc=12.
REQ-034 RUN, i_stall=1 for 3 cycles at PC=8 -> o_pc stays 8, o_instr/o_valid unchanged; release -> fetch resumes at 8.
REQ-035 RUN at PC=4, i_pc_src=01, i_branch_target=0x40, i_flush=1, i_stall=1 -> next cycle o_pc=0x40, o_instr=0, o_valid=0; following cycle o_instr=mem[16].
REQ-036 In RUN, i_load_en=1 addr 0 data 0xDEADBEEF -> memory word 0 unchanged after returning to IDLE and rerunning.
REQ-037 Reset low mid-RUN at PC=0x20 -> all outputs 0 immediately, state IDLE; no fetch until i_start.
REQ-038 i_pc_src=11, i_jr_target=0x3FC with NB_ADDR=8 -> fetch word 255; next sequential PC 0x400 fetches word 0 (index wrap).
